// File: rtl/p405s_dcu_bist_pkg.sv
// Shared types for the DCU data-array BIST initiator: FSM states, March C-
// element encoding, per-element operation table and an op-decode helper.
package p405s_dcu_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } bistState_e;

   typedef enum logic [2:0] {
      E0 = 3'd0,
      E1 = 3'd1,
      E2 = 3'd2,
      E3 = 3'd3,
      E4 = 3'd4,
      E5 = 3'd5
   } marchElem_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } marchOp_e;

   // down: address sweep direction; twoOp: read-then-write at each address;
   // firstOp: op of single-op elements (and the read of two-op elements);
   // rdPol/wrPol: 0 = background, 1 = inverted background.
   typedef struct packed {
      logic     down;
      logic     twoOp;
      marchOp_e firstOp;
      logic     rdPol;
      logic     wrPol;
   } elemCfg_t;

   // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0).
   // Two trailing entries pad the table to the full 3-bit index range.
   localparam elemCfg_t ELEM_TABLE [8] = '{
      '{1'b0, 1'b0, OP_WR, 1'b0, 1'b0},
      '{1'b0, 1'b1, OP_RD, 1'b0, 1'b1},
      '{1'b0, 1'b1, OP_RD, 1'b1, 1'b0},
      '{1'b1, 1'b1, OP_RD, 1'b0, 1'b1},
      '{1'b1, 1'b1, OP_RD, 1'b1, 1'b0},
      '{1'b0, 1'b0, OP_RD, 1'b0, 1'b0},
      '{1'b0, 1'b0, OP_RD, 1'b0, 1'b0},
      '{1'b0, 1'b0, OP_RD, 1'b0, 1'b0}
   };

   // Operation performed by element e in phase 0 (first op) or 1 (second op).
   function automatic marchOp_e opAt(input marchElem_e e, input logic phase);
      return (ELEM_TABLE[e].twoOp && phase) ? OP_WR : ELEM_TABLE[e].firstOp;
   endfunction

endpackage

// File: rtl/p405s_dcu_bist_cmp.sv
// Expected-data pipe and read-data compare for one memory of the data array.
// Ports:
//   CB, reset   clock / synchronous active-high reset
//   rdIssue     a read is presented to the memory this cycle
//   expData     data that read should return
//   rdData      memory read data (valid the cycle after the read)
//   mismatch_c  combinational miscompare for the read issued last cycle
module p405s_dcu_bist_cmp
   import p405s_dcu_bist_pkg::*;
#(
   parameter int unsigned DW = 128
) (
   input  logic          CB,
   input  logic          reset,
   input  logic          rdIssue,
   input  logic [DW-1:0] expData,
   input  logic [DW-1:0] rdData,
   output logic          mismatch_c
);

   logic          validQ;
   logic [DW-1:0] expQ;

   // Hold the expectation for one cycle to line up with the memory latency.
   always_ff @(posedge CB) begin
      if (reset) begin
         validQ <= 1'b0;
         expQ   <= '0;
      end else begin
         validQ <= rdIssue;
         if (rdIssue) begin
            expQ <= expData;
         end
      end
   end

   assign mismatch_c = validQ && (rdData != expQ);

endmodule

// File: rtl/p405s_dcu_dataarray_bistctl.sv
// March C- BIST initiator for the 16K DCU data array. Drives the two 128b data
// RAMs (m0/m1) and the 32b parity RAM (m2) in lock-step, checks every read one
// cycle later and reports pass/fail with first-failure capture.
// Ports:
//   CB, reset              clock / synchronous active-high reset
//   bist_start             level request, honoured in IDLE and DONE only
//   bist_done/bist_fail    completion and sticky miscompare flags
//   bist_fail_mem/addr/elem first failure: one-hot {m2,m1,m0}, address, element
//   bist_mode              steers the array onto the BIST path
//   bist_ce_n/we_n/addr/wr_data_m*  memory controls (active-low enables)
//   bist_rd_data_m*        memory read data, valid one cycle after a read
module p405s_dcu_dataarray_bistctl
   import p405s_dcu_bist_pkg::*;
#(
   parameter int unsigned        ADDR_W  = 9,
   parameter int unsigned        DW_DATA = 128,
   parameter int unsigned        DW_PAR  = 32,
   parameter logic [DW_DATA-1:0] BG      = '0
) (
   input  logic               CB,
   input  logic               reset,
   input  logic               bist_start,
   output logic               bist_done,
   output logic               bist_fail,
   output logic [2:0]         bist_fail_mem,
   output logic [ADDR_W-1:0]  bist_fail_addr,
   output logic [2:0]         bist_fail_elem,
   output logic               bist_mode,
   output logic               bist_ce_n_m0,
   output logic               bist_ce_n_m1,
   output logic               bist_ce_n_m2,
   output logic               bist_we_n_m0,
   output logic               bist_we_n_m1,
   output logic               bist_we_n_m2,
   output logic [ADDR_W-1:0]  bist_addr_m0,
   output logic [ADDR_W-1:0]  bist_addr_m1,
   output logic [ADDR_W-1:0]  bist_addr_m2,
   output logic [DW_DATA-1:0] bist_wr_data_m0,
   output logic [DW_DATA-1:0] bist_wr_data_m1,
   output logic [DW_PAR-1:0]  bist_wr_data_m2,
   input  logic [DW_DATA-1:0] bist_rd_data_m0,
   input  logic [DW_DATA-1:0] bist_rd_data_m1,
   input  logic [DW_PAR-1:0]  bist_rd_data_m2
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   bistState_e          stateQ, stateD;
   marchElem_e          elemQ, elemD, nxtElem;
   logic [ADDR_W-1:0]   addrQ, addrD;
   logic                phaseQ, phaseD;
   logic                opLoad, clrRes;

   logic                modeQ, modeD;
   logic                doneQ, doneD;
   logic                ceNQ, ceND;
   logic                weNQ, weND;
   logic [ADDR_W-1:0]   addrOutQ, addrOutD;
   logic [DW_DATA-1:0]  wrDataQ, wrDataD;

   logic                rdIssue;
   logic [DW_DATA-1:0]  expData;
   logic [ADDR_W-1:0]   cmpAddrQ;
   marchElem_e          cmpElemQ;
   logic [2:0]          mism;

   logic                failQ;
   logic [2:0]          failMemQ;
   logic [ADDR_W-1:0]   failAddrQ;
   marchElem_e          failElemQ;

   // State, march position and registered memory controls.
   always_ff @(posedge CB) begin
      if (reset) begin
         stateQ   <= ST_IDLE;
         elemQ    <= E0;
         addrQ    <= '0;
         phaseQ   <= 1'b0;
         modeQ    <= 1'b0;
         doneQ    <= 1'b0;
         ceNQ     <= 1'b1;
         weNQ     <= 1'b1;
         addrOutQ <= '0;
         wrDataQ  <= '0;
      end else begin
         stateQ   <= stateD;
         elemQ    <= elemD;
         addrQ    <= addrD;
         phaseQ   <= phaseD;
         modeQ    <= modeD;
         doneQ    <= doneD;
         ceNQ     <= ceND;
         weNQ     <= weND;
         addrOutQ <= addrOutD;
         wrDataQ  <= wrDataD;
      end
   end

   // Next-state, march sequencing and next memory-control values.
   always_comb begin
      stateD   = stateQ;
      elemD    = elemQ;
      addrD    = addrQ;
      phaseD   = phaseQ;
      opLoad   = 1'b0;
      clrRes   = 1'b0;
      modeD    = 1'b0;
      doneD    = 1'b0;
      ceND     = 1'b1;
      weND     = 1'b1;
      addrOutD = '0;
      wrDataD  = '0;
      nxtElem  = (elemQ == E5) ? E5 : marchElem_e'(elemQ + 3'd1);

      case (stateQ)
         ST_IDLE, ST_DONE: begin
            if (bist_start) begin
               stateD = ST_SETUP;
               clrRes = 1'b1;
            end
         end
         ST_SETUP: begin
            stateD = ST_RUN;
            elemD  = E0;
            addrD  = '0;
            phaseD = 1'b0;
            opLoad = 1'b1;
         end
         ST_RUN: begin
            if (ELEM_TABLE[elemQ].twoOp && !phaseQ) begin
               phaseD = 1'b1;
               opLoad = 1'b1;
            end else begin
               phaseD = 1'b0;
               if (ELEM_TABLE[elemQ].down ? (addrQ == '0) : (addrQ == ADDR_MAX)) begin
                  // Terminal address: move to the next element with no bubble.
                  if (elemQ == E5) begin
                     stateD = ST_DRAIN;
                  end else begin
                     elemD  = nxtElem;
                     addrD  = ELEM_TABLE[nxtElem].down ? ADDR_MAX : '0;
                     opLoad = 1'b1;
                  end
               end else begin
                  addrD  = ELEM_TABLE[elemQ].down ? (addrQ - ADDR_W'(1)) : (addrQ + ADDR_W'(1));
                  opLoad = 1'b1;
               end
            end
         end
         ST_DRAIN: stateD = ST_DONE;
         default:  stateD = ST_IDLE;
      endcase

      modeD = (stateD == ST_SETUP) || (stateD == ST_RUN) || (stateD == ST_DRAIN);
      doneD = (stateD == ST_DONE);

      if (opLoad) begin
         ceND     = 1'b0;
         addrOutD = addrD;
         if (opAt(elemD, phaseD) == OP_WR) begin
            weND    = 1'b0;
            wrDataD = ELEM_TABLE[elemD].wrPol ? ~BG : BG;
         end
      end
   end

   // The op on the outputs this cycle is described by elemQ/addrQ/phaseQ.
   assign rdIssue = !ceNQ && weNQ;
   assign expData = ELEM_TABLE[elemQ].rdPol ? ~BG : BG;

   // Address/element of the read whose data is being compared.
   always_ff @(posedge CB) begin
      if (reset) begin
         cmpAddrQ <= '0;
         cmpElemQ <= E0;
      end else if (rdIssue) begin
         cmpAddrQ <= addrQ;
         cmpElemQ <= elemQ;
      end
   end

   p405s_dcu_bist_cmp #(.DW(DW_DATA)) uCmpM0 (
      .CB         (CB),
      .reset      (reset),
      .rdIssue    (rdIssue),
      .expData    (expData),
      .rdData     (bist_rd_data_m0),
      .mismatch_c (mism[0])
   );

   p405s_dcu_bist_cmp #(.DW(DW_DATA)) uCmpM1 (
      .CB         (CB),
      .reset      (reset),
      .rdIssue    (rdIssue),
      .expData    (expData),
      .rdData     (bist_rd_data_m1),
      .mismatch_c (mism[1])
   );

   p405s_dcu_bist_cmp #(.DW(DW_PAR)) uCmpM2 (
      .CB         (CB),
      .reset      (reset),
      .rdIssue    (rdIssue),
      .expData    (expData[DW_PAR-1:0]),
      .rdData     (bist_rd_data_m2),
      .mismatch_c (mism[2])
   );

   // Sticky fail flag; only the first miscompare records its details.
   always_ff @(posedge CB) begin
      if (reset || clrRes) begin
         failQ     <= 1'b0;
         failMemQ  <= '0;
         failAddrQ <= '0;
         failElemQ <= E0;
      end else if (|mism) begin
         failQ <= 1'b1;
         if (!failQ) begin
            failMemQ  <= mism;
            failAddrQ <= cmpAddrQ;
            failElemQ <= cmpElemQ;
         end
      end
   end

   assign bist_done       = doneQ;
   assign bist_fail       = failQ;
   assign bist_fail_mem   = failMemQ;
   assign bist_fail_addr  = failAddrQ;
   assign bist_fail_elem  = failElemQ;
   assign bist_mode       = modeQ;
   assign bist_ce_n_m0    = ceNQ;
   assign bist_ce_n_m1    = ceNQ;
   assign bist_ce_n_m2    = ceNQ;
   assign bist_we_n_m0    = weNQ;
   assign bist_we_n_m1    = weNQ;
   assign bist_we_n_m2    = weNQ;
   assign bist_addr_m0    = addrOutQ;
   assign bist_addr_m1    = addrOutQ;
   assign bist_addr_m2    = addrOutQ;
   assign bist_wr_data_m0 = wrDataQ;
   assign bist_wr_data_m1 = wrDataQ;
   assign bist_wr_data_m2 = wrDataQ[DW_PAR-1:0];

endmodule

// File: tb/tb_p405s_dcu_dataarray_bistctl.sv
// Directed bench for the DCU data-array BIST initiator with behavioural
// memories and switchable fault models.
module tb_p405s_dcu_dataarray_bistctl;

   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned DW_DATA = 128;
   localparam int unsigned DW_PAR  = 32;
   localparam int unsigned DEPTH   = 512;

   logic               CB = 1'b0;
   logic               reset = 1'b1;
   logic               bist_start = 1'b0;
   logic               bist_done, bist_fail, bist_mode;
   logic [2:0]         bist_fail_mem, bist_fail_elem;
   logic [ADDR_W-1:0]  bist_fail_addr;
   logic               bist_ce_n_m0, bist_ce_n_m1, bist_ce_n_m2;
   logic               bist_we_n_m0, bist_we_n_m1, bist_we_n_m2;
   logic [ADDR_W-1:0]  bist_addr_m0, bist_addr_m1, bist_addr_m2;
   logic [DW_DATA-1:0] bist_wr_data_m0, bist_wr_data_m1;
   logic [DW_PAR-1:0]  bist_wr_data_m2;
   logic [DW_DATA-1:0] bist_rd_data_m0, bist_rd_data_m1;
   logic [DW_PAR-1:0]  bist_rd_data_m2;

   int unsigned edgeCnt = 0;
   int          checks  = 0;
   int          errors  = 0;

   // Fault enables: m2 bit5 SA1 @1A5; m0 bit77 / m1 bit3 SA0 @000;
   // m1 bit0 of 1FF flips when read straight after a write to 1FF.
   bit fltM2  = 1'b0;
   bit fltM01 = 1'b0;
   bit fltM1c = 1'b0;

   logic [DW_DATA-1:0] mem0 [DEPTH];
   logic [DW_DATA-1:0] mem1 [DEPTH];
   logic [DW_PAR-1:0]  mem2 [DEPTH];
   logic               prevWr1 = 1'b0;
   logic [ADDR_W-1:0]  prevA1  = '0;

   p405s_dcu_dataarray_bistctl dut (
      .CB              (CB),
      .reset           (reset),
      .bist_start      (bist_start),
      .bist_done       (bist_done),
      .bist_fail       (bist_fail),
      .bist_fail_mem   (bist_fail_mem),
      .bist_fail_addr  (bist_fail_addr),
      .bist_fail_elem  (bist_fail_elem),
      .bist_mode       (bist_mode),
      .bist_ce_n_m0    (bist_ce_n_m0),
      .bist_ce_n_m1    (bist_ce_n_m1),
      .bist_ce_n_m2    (bist_ce_n_m2),
      .bist_we_n_m0    (bist_we_n_m0),
      .bist_we_n_m1    (bist_we_n_m1),
      .bist_we_n_m2    (bist_we_n_m2),
      .bist_addr_m0    (bist_addr_m0),
      .bist_addr_m1    (bist_addr_m1),
      .bist_addr_m2    (bist_addr_m2),
      .bist_wr_data_m0 (bist_wr_data_m0),
      .bist_wr_data_m1 (bist_wr_data_m1),
      .bist_wr_data_m2 (bist_wr_data_m2),
      .bist_rd_data_m0 (bist_rd_data_m0),
      .bist_rd_data_m1 (bist_rd_data_m1),
      .bist_rd_data_m2 (bist_rd_data_m2)
   );

   always #5 CB = ~CB;
   always @(posedge CB) edgeCnt <= edgeCnt + 1;

   always @(posedge CB) begin : m0Model
      logic [DW_DATA-1:0] d;
      if (!bist_ce_n_m0) begin
         if (!bist_we_n_m0) mem0[bist_addr_m0] <= bist_wr_data_m0;
         else begin
            d = mem0[bist_addr_m0];
            if (fltM01 && bist_addr_m0 == 9'h000) d[77] = 1'b0;
            bist_rd_data_m0 <= d;
         end
      end
   end

   always @(posedge CB) begin : m1Model
      logic [DW_DATA-1:0] d;
      if (!bist_ce_n_m1) begin
         if (!bist_we_n_m1) mem1[bist_addr_m1] <= bist_wr_data_m1;
         else begin
            d = mem1[bist_addr_m1];
            if (fltM01 && bist_addr_m1 == 9'h000) d[3] = 1'b0;
            if (fltM1c && bist_addr_m1 == 9'h1FF && prevWr1 && prevA1 == 9'h1FF) d[0] = ~d[0];
            bist_rd_data_m1 <= d;
         end
         prevWr1 <= !bist_we_n_m1;
         prevA1  <= bist_addr_m1;
      end
   end

   always @(posedge CB) begin : m2Model
      logic [DW_PAR-1:0] d;
      if (!bist_ce_n_m2) begin
         if (!bist_we_n_m2) mem2[bist_addr_m2] <= bist_wr_data_m2;
         else begin
            d = mem2[bist_addr_m2];
            if (fltM2 && bist_addr_m2 == 9'h1A5) d[5] = 1'b1;
            bist_rd_data_m2 <= d;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic gotoCycle(input int unsigned n);
      while (edgeCnt < n) begin
         @(posedge CB);
         #1;
      end
   endtask

   task automatic waitDone();
      int n = 0;
      while (!bist_done && n < 6000) begin
         @(posedge CB);
         #1;
         n++;
      end
      chk("done_reached", bist_done, 1'b1);
   endtask

   task automatic runTest();
      bist_start = 1'b1;
      @(posedge CB);
      #1;
      bist_start = 1'b0;
      waitDone();
   endtask

   task automatic chkQuiet(input string tag);
      chk({tag, "_mode"}, bist_mode, 1'b0);
      chk({tag, "_ce_n"}, {bist_ce_n_m2, bist_ce_n_m1, bist_ce_n_m0}, 3'b111);
      chk({tag, "_we_n"}, {bist_we_n_m2, bist_we_n_m1, bist_we_n_m0}, 3'b111);
      chk({tag, "_done"}, bist_done, 1'b0);
      chk({tag, "_fail"}, bist_fail, 1'b0);
      chk({tag, "_fmem"}, bist_fail_mem, 3'b000);
      chk({tag, "_faddr"}, bist_fail_addr, 9'h000);
      chk({tag, "_felem"}, bist_fail_elem, 3'd0);
   endtask

   initial begin
      // Reset state
      gotoCycle(2);
      chkQuiet("rst");
      chk("rst_addr", bist_addr_m0, 9'h000);
      chk("rst_wdata", bist_wr_data_m0, 128'h0);
      reset = 1'b0;

      // Fault-free run with cycle-exact sequencing checks
      gotoCycle(10);
      bist_start = 1'b1;
      gotoCycle(11);
      bist_start = 1'b0;
      chk("setup_mode", bist_mode, 1'b1);
      chk("setup_ce_n", {bist_ce_n_m2, bist_ce_n_m1, bist_ce_n_m0}, 3'b111);
      gotoCycle(12);
      chk("e0_ce_we", {bist_ce_n_m2, bist_ce_n_m1, bist_ce_n_m0, bist_we_n_m2, bist_we_n_m1, bist_we_n_m0}, 6'b000000);
      chk("e0_addr", bist_addr_m2, 9'h000);
      chk("e0_wdata", bist_wr_data_m0, 128'h0);
      gotoCycle(13);
      chk("e0_addr1", bist_addr_m1, 9'h001);
      gotoCycle(524);
      chk("e1_rd_we", {bist_ce_n_m0, bist_we_n_m0}, 2'b01);
      chk("e1_rd_addr", bist_addr_m0, 9'h000);
      gotoCycle(525);
      chk("e1_wr_we", {bist_ce_n_m2, bist_we_n_m2}, 2'b00);
      chk("e1_wr_m2", bist_wr_data_m2, 32'hFFFF_FFFF);
      chk("e1_wr_m1", bist_wr_data_m1, {128{1'b1}});
      gotoCycle(1549);
      chk("e2_wr_m0", bist_wr_data_m0, 128'h0);
      gotoCycle(2572);
      chk("e3_rd", {bist_addr_m0, bist_we_n_m0}, {9'h1FF, 1'b1});
      gotoCycle(2573);
      chk("e3_wr", {bist_addr_m1, bist_we_n_m1}, {9'h1FF, 1'b0});
      gotoCycle(2574);
      chk("e3_dn", {bist_addr_m2, bist_we_n_m2}, {9'h1FE, 1'b1});
      gotoCycle(4621);
      chk("e5_single", {bist_addr_m0, bist_ce_n_m0, bist_we_n_m0}, {9'h001, 2'b01});
      gotoCycle(5131);
      chk("last_rd", {bist_addr_m0, bist_ce_n_m0, bist_we_n_m0}, {9'h1FF, 2'b01});
      gotoCycle(5132);
      chk("drain", {bist_mode, bist_ce_n_m0, bist_done}, 3'b110);
      gotoCycle(5133);
      chk("done_at", {bist_done, bist_mode, bist_fail}, 3'b100);
      gotoCycle(5140);
      chk("done_held", {bist_done, bist_fail, bist_fail_mem}, 5'b10000);

      // m2 stuck-at-1
      fltM2 = 1'b1;
      runTest();
      chk("m2_fail", bist_fail, 1'b1);
      chk("m2_fmem", bist_fail_mem, 3'b100);
      chk("m2_faddr", bist_fail_addr, 9'h1A5);
      chk("m2_felem", bist_fail_elem, 3'd1);
      fltM2 = 1'b0;

      // m0+m1 simultaneous stuck-at-0
      fltM01 = 1'b1;
      runTest();
      chk("m01_fail", bist_fail, 1'b1);
      chk("m01_fmem", bist_fail_mem, 3'b011);
      chk("m01_faddr", bist_fail_addr, 9'h000);
      chk("m01_felem", bist_fail_elem, 3'd2);
      fltM01 = 1'b0;

      // m1 fault only visible at the up-to-down turnaround
      fltM1c = 1'b1;
      runTest();
      chk("cpl_fail", bist_fail, 1'b1);
      chk("cpl_fmem", bist_fail_mem, 3'b010);
      chk("cpl_faddr", bist_fail_addr, 9'h1FF);
      chk("cpl_felem", bist_fail_elem, 3'd3);
      fltM1c = 1'b0;

      // Reset in the middle of a failing run
      fltM2 = 1'b1;
      bist_start = 1'b1;
      @(posedge CB);
      #1;
      bist_start = 1'b0;
      repeat (2000) @(posedge CB);
      #1;
      chk("mid_pre_fail", {bist_mode, bist_fail}, 2'b11);
      reset = 1'b1;
      @(posedge CB);
      #1;
      chkQuiet("mid_rst");
      reset = 1'b0;
      fltM2 = 1'b0;
      runTest();
      chk("rerun_fail", {bist_fail, bist_fail_mem}, 4'b0000);

      // Start held high: restart straight from DONE clears the results
      fltM01 = 1'b1;
      bist_start = 1'b1;
      @(posedge CB);
      #1;
      waitDone();
      chk("hold1_fail", {bist_fail, bist_fail_mem, bist_fail_elem}, {1'b1, 3'b011, 3'd2});
      fltM01 = 1'b0;
      @(posedge CB);
      #1;
      chk("hold_restart", {bist_done, bist_fail, bist_fail_mem, bist_mode}, {1'b0, 1'b0, 3'b000, 1'b1});
      repeat (100) @(posedge CB);
      #1;
      bist_start = 1'b0;
      waitDone();
      chk("hold2_fail", {bist_fail, bist_fail_mem}, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
